mem_write_checker: RTL and testbench
====================================

# mem_write_checker

Synthesizable store-sequence checker for pipelined MIPS bring-up. Watches the data-memory write port (`memwrite`, `dataadr`, `writedata`) and compares each store, in order, against a loadable table of DEPTH expected address/data pairs. Stores to one configurable "don't care" address are skipped. Reports sticky pass/fail status and diagnostics, replacing hand-coded negedge checks with a reusable block instantiated beside `top`.

## Interface
- `DEPTH`, 2: number of expected stores, ≥1
- `AW`, 32: address width
- `DW`, 32: data width
- `IGNORE_ADDR`, 80: stores to this address are skipped and counted
- `TIMEOUT_CYCLES`, 1000: watchdog limit, used only with the macro
- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `exp_we`  in  1  write expected-table entry; honoured only in IDLE
- `exp_idx`  in  $clog2(DEPTH)  table entry index
- `exp_addr`  in  AW  expected address
- `exp_data`  in  DW  expected data
- `start`  in  1  arm the checker and clear status
- `memwrite`  in  1  store strobe from the DUT
- `dataadr`  in  AW  store address
- `writedata`  in  DW  store data
- `busy`  out  1  high in RUN
- `pass`  out  1  sticky; all DEPTH stores matched
- `fail`  out  1  sticky; mismatch, overrun or timeout
- `fail_idx`  out  $clog2(DEPTH+1)  entry being checked at failure; DEPTH means overrun
- `bad_addr`  out  AW  captured offending address; 0 on timeout
- `bad_data`  out  DW  captured offending data; 0 on timeout
- `match_cnt`  out  $clog2(DEPTH+1)  stores matched so far
- `ignore_cnt`  out  16  skipped stores; saturates at 0xFFFF

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE:
  - `exp_we` writes entry `exp_idx`.
  - `memwrite` is ignored.
  - `start` clears `match_cnt`, `ignore_cnt`, `fail_idx`, `bad_addr`, `bad_data`, then enters RUN.
- RUN, on `memwrite`, with idx = `match_cnt`:
  - If `dataadr==exp_addr[idx]` and `writedata==exp_data[idx]`: increment `match_cnt`. If the new count equals DEPTH, go to PASS.
  - Else if `dataadr==IGNORE_ADDR`: increment `ignore_cnt` and stay in RUN. A table match takes priority over the ignore address.
  - Else: go to FAIL. Set `fail_idx`=idx and capture `dataadr` and `writedata`.
- PASS:
  - A store to `IGNORE_ADDR` increments `ignore_cnt`.
  - Any other store is an overrun: go to FAIL with `fail_idx`=DEPTH and capture the store.
- FAIL: terminal; later stores are ignored.
- From RUN, PASS or FAIL, `start` re-arms. The table is kept, counters are cleared, next state is RUN.
- `exp_we` outside IDLE is dropped.
- `pass` = (state==PASS); `fail` = (state==FAIL); `busy` = (state==RUN).
- The table is not cleared by reset.

## Timing
- Reset values: state IDLE; every output 0; `ignore_cnt` 0.
- All outputs are registered. A store sampled at edge k is reflected in outputs right after edge k (1-cycle latency).
- `start` sampled at edge k: `busy`=1 after edge k. A store sampled at the same edge is not checked.
- A store in back-to-back cycles is checked every cycle; no bubble is required.
- Reset asserted mid-RUN: immediately returns to IDLE with all outputs 0.
- Comparison is 4-state-unsafe RTL equality. X on the inputs is not a goal.

## Configuration
- `MEM_CHECKER_TIMEOUT_EN` defined:
  - A cycle counter clears on `start` and on every table match.
  - If it reaches `TIMEOUT_CYCLES` in RUN, go to FAIL with `fail_idx`=`match_cnt` and `bad_addr`/`bad_data`=0.
  - Ignored stores do not clear the counter.
- Undefined: no counter, no timeout; RUN may last forever.

## Structure
- `mem_checker_pkg`: `chk_state_t` enum (IDLE, RUN, PASS, FAIL) and a default ignore-address constant.
- One sub-module, `exp_table`: a DEPTH×(AW+DW) register file with a single write port and a combinational read at `match_cnt`.
- The FSM, counters and capture registers stay in the top module.

## Test plan
DEPTH=2; table {60,230}, {61,29}.
- Nominal: `start`, then stores (60,230) and (61,29) → `pass`=1, `match_cnt`=2, `fail`=0.
- Ignore: stores (60,230), (80,5), (61,29) → `pass`=1, `ignore_cnt`=1.
- Mismatch: store (60,231) → `fail`=1, `fail_idx`=0, `bad_data`=231, `busy`=0.
- Overrun: nominal sequence then (64,1) → `fail`=1, `fail_idx`=2, `bad_addr`=64.
- Reset and re-arm:
  - Reset low after the first match → all outputs 0, state IDLE.
  - Then `start` and the nominal sequence → `pass`=1, because the table is retained.
- Timeout, with the macro and TIMEOUT_CYCLES=10: `start`, then no stores for 10 cycles → `fail`=1, `fail_idx`=0, `bad_addr`=0.

Source files
------------

// File: rtl/mem_checker_pkg.sv
// mem_checker_pkg: shared state encoding and defaults for the store-sequence checker.
package mem_checker_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} chk_state_t;
    localparam int unsigned DEFAULT_IGNORE_ADDR = 80;
endpackage

// File: rtl/exp_table.sv
// exp_table: DEPTH-entry expected address/data register file, one write port, combinational read.
module exp_table #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned IW    = 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] ridx,
    output logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    // No reset: the table must survive a checker reset.
    logic [AW+DW-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem_q[widx] <= {waddr, wdata};
    end
    assign {raddr, rdata} = mem_q[ridx];
endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: in-order data-memory store checker with sticky pass/fail and diagnostics.
// Optional watchdog enabled by defining MEM_CHECKER_TIMEOUT_EN.
module mem_write_checker
    import mem_checker_pkg::*;
#(
    parameter int unsigned DEPTH          = 2,
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned IGNORE_ADDR    = DEFAULT_IGNORE_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          exp_we,
    input  logic [IW-1:0] exp_idx,
    input  logic [AW-1:0] exp_addr,
    input  logic [DW-1:0] exp_data,
    input  logic          start,
    input  logic          memwrite,
    input  logic [AW-1:0] dataadr,
    input  logic [DW-1:0] writedata,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic [CW-1:0] fail_idx,
    output logic [AW-1:0] bad_addr,
    output logic [DW-1:0] bad_data,
    output logic [CW-1:0] match_cnt,
    output logic [15:0]   ignore_cnt
);
    chk_state_t    state_q, state_d;
    logic [CW-1:0] match_q, match_d, fidx_q, fidx_d;
    logic [AW-1:0] baddr_q, baddr_d, e_addr;
    logic [DW-1:0] bdata_q, bdata_d, e_data;
    logic [15:0]   ign_q, ign_d;
    logic          hit, ign;
`ifdef MEM_CHECKER_TIMEOUT_EN
    logic [31:0]   tmo_q, tmo_d;
`endif

    exp_table #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .IW(IW)) u_tbl (
        .clk   (clk),
        .we    (exp_we && state_q == IDLE),
        .widx  (exp_idx),
        .waddr (exp_addr),
        .wdata (exp_data),
        .ridx  (match_q[IW-1:0]),
        .raddr (e_addr),
        .rdata (e_data)
    );

    assign hit = (dataadr == e_addr) && (writedata == e_data);
    assign ign = dataadr == AW'(IGNORE_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            match_q <= '0;
            fidx_q  <= '0;
            baddr_q <= '0;
            bdata_q <= '0;
            ign_q   <= '0;
`ifdef MEM_CHECKER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            fidx_q  <= fidx_d;
            baddr_q <= baddr_d;
            bdata_q <= bdata_d;
            ign_q   <= ign_d;
`ifdef MEM_CHECKER_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        fidx_d  = fidx_q;
        baddr_d = baddr_q;
        bdata_d = bdata_q;
        ign_d   = ign_q;
`ifdef MEM_CHECKER_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        if (start) begin
            state_d = RUN;
            match_d = '0;
            fidx_d  = '0;
            baddr_d = '0;
            bdata_d = '0;
            ign_d   = '0;
`ifdef MEM_CHECKER_TIMEOUT_EN
            tmo_d   = '0;
`endif
        end else if (state_q == RUN) begin
            if (memwrite && hit) begin
                match_d = match_q + CW'(1);
                state_d = (match_q == CW'(DEPTH - 1)) ? PASS : RUN;
            end else if (memwrite && ign) begin
                ign_d = (ign_q == 16'hFFFF) ? ign_q : ign_q + 16'd1;
            end else if (memwrite) begin
                state_d = FAIL;
                fidx_d  = match_q;
                baddr_d = dataadr;
                bdata_d = writedata;
            end
`ifdef MEM_CHECKER_TIMEOUT_EN
            tmo_d = (memwrite && hit) ? '0 : tmo_q + 32'd1;
            if (state_d == RUN && !(memwrite && hit) && tmo_q + 32'd1 == TIMEOUT_CYCLES) begin
                state_d = FAIL;
                fidx_d  = match_q;
                baddr_d = '0;
                bdata_d = '0;
            end
`endif
        end else if (state_q == PASS && memwrite) begin
            if (ign) begin
                ign_d = (ign_q == 16'hFFFF) ? ign_q : ign_q + 16'd1;
            end else begin
                state_d = FAIL;
                fidx_d  = CW'(DEPTH);
                baddr_d = dataadr;
                bdata_d = writedata;
            end
        end
    end

    always_comb begin
        busy       = state_q == RUN;
        pass       = state_q == PASS;
        fail       = state_q == FAIL;
        fail_idx   = fidx_q;
        bad_addr   = baddr_q;
        bad_data   = bdata_q;
        match_cnt  = match_q;
        ignore_cnt = ign_q;
    end
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed stores with a scoreboard of hand-computed expected outputs.
module tb_mem_write_checker;
    logic        clk = 1'b0, reset = 1'b0, exp_we = 1'b0, start = 1'b0, memwrite = 1'b0;
    logic [0:0]  exp_idx = '0;
    logic [31:0] exp_addr = '0, exp_data = '0, dataadr = '0, writedata = '0;
    logic        busy, pass, fail;
    logic [1:0]  fail_idx, match_cnt;
    logic [31:0] bad_addr, bad_data;
    logic [15:0] ignore_cnt;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        string       name;
        logic        busy, pass, fail;
        logic [1:0]  fidx;
        logic [31:0] baddr, bdata;
        logic [1:0]  mcnt;
        logic [15:0] icnt;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    mem_write_checker #(
        .DEPTH(2), .AW(32), .DW(32), .IGNORE_ADDR(80),
`ifdef MEM_CHECKER_TIMEOUT_EN
        .TIMEOUT_CYCLES(10)
`else
        .TIMEOUT_CYCLES(1000)
`endif
    ) dut (
        .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
        .exp_data(exp_data), .start(start), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .busy(busy), .pass(pass), .fail(fail), .fail_idx(fail_idx),
        .bad_addr(bad_addr), .bad_data(bad_data), .match_cnt(match_cnt), .ignore_cnt(ignore_cnt)
    );

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if ({busy, pass, fail, fail_idx, bad_addr, bad_data, match_cnt, ignore_cnt} !==
                {e.busy, e.pass, e.fail, e.fidx, e.baddr, e.bdata, e.mcnt, e.icnt}) begin
                n_fail++;
                $display("FAIL %s: got busy=%0b pass=%0b fail=%0b fidx=%0d baddr=%0d bdata=%0d match=%0d ign=%0d; want busy=%0b pass=%0b fail=%0b fidx=%0d baddr=%0d bdata=%0d match=%0d ign=%0d",
                         e.name, busy, pass, fail, fail_idx, bad_addr, bad_data, match_cnt, ignore_cnt,
                         e.busy, e.pass, e.fail, e.fidx, e.baddr, e.bdata, e.mcnt, e.icnt);
            end
        end
    end

    task automatic chk(input string n, input logic b, p, f, input logic [1:0] fi,
                       input logic [31:0] ba, bd, input logic [1:0] mc, input logic [15:0] ic);
        q.push_back('{n, b, p, f, fi, ba, bd, mc, ic});
    endtask

    task automatic step(input logic st, mw, input logic [31:0] a, d);
        @(negedge clk); #1;
        start = st; memwrite = mw; dataadr = a; writedata = d;
        @(posedge clk); #1;
        start = 1'b0; memwrite = 1'b0;
    endtask

    task automatic wr(input logic [0:0] i, input logic [31:0] a, d);
        @(negedge clk); #1;
        exp_we = 1'b1; exp_idx = i; exp_addr = a; exp_data = d;
        @(posedge clk); #1;
        exp_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b0;
        #1 chk("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); @(negedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        chk("por", 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 reset = 1'b1;
        wr(0, 60, 230);
        wr(1, 61, 29);
        step(0, 1, 60, 230);         chk("idle_store", 0, 0, 0, 0, 0, 0, 0, 0);
        // Nominal
        step(1, 0, 0, 0);            chk("start", 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 60, 230);         chk("nom_m1", 1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 61, 29);          chk("nom_pass", 0, 1, 0, 0, 0, 0, 2, 0);
        // Ignore address inside RUN and after PASS
        step(1, 0, 0, 0);            chk("rearm", 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 60, 230);         chk("ign_m1", 1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 80, 5);           chk("ign_skip", 1, 0, 0, 0, 0, 0, 1, 1);
        step(0, 1, 61, 29);          chk("ign_pass", 0, 1, 0, 0, 0, 0, 2, 1);
        step(0, 1, 80, 7);           chk("pass_ign", 0, 1, 0, 0, 0, 0, 2, 2);
        // Data mismatch at entry 0, then FAIL is terminal
        step(1, 0, 0, 0);            chk("rearm2", 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 60, 231);         chk("mismatch", 0, 0, 1, 0, 60, 231, 0, 0);
        step(0, 1, 60, 230);         chk("fail_sticky", 0, 0, 1, 0, 60, 231, 0, 0);
        // Overrun after PASS
        step(1, 0, 0, 0);            chk("rearm3", 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 60, 230);         chk("ovr_m1", 1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 61, 29);          chk("ovr_pass", 0, 1, 0, 0, 0, 0, 2, 0);
        step(0, 1, 64, 1);           chk("overrun", 0, 0, 1, 2, 64, 1, 2, 0);
        // Store coincident with start is not checked; table writes outside IDLE are dropped
        step(1, 1, 60, 230);         chk("start_store", 1, 0, 0, 0, 0, 0, 0, 0);
        wr(0, 99, 99);
        step(0, 1, 60, 230);         chk("we_dropped", 1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 62, 29);          chk("addr_mismatch", 0, 0, 1, 1, 62, 29, 1, 0);
        // Reset mid-RUN, then re-arm with the retained table
        step(1, 0, 0, 0);            chk("rearm4", 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 60, 230);         chk("pre_rst_m1", 1, 0, 0, 0, 0, 0, 1, 0);
        do_reset();
        step(1, 0, 0, 0);            chk("post_rst_start", 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 60, 230);         chk("post_rst_m1", 1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 61, 29);          chk("post_rst_pass", 0, 1, 0, 0, 0, 0, 2, 0);
`ifdef MEM_CHECKER_TIMEOUT_EN
        step(1, 0, 0, 0);            chk("tmo_start", 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0);
        step(0, 0, 0, 0);            chk("tmo_9", 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0);            chk("timeout", 0, 0, 1, 0, 0, 0, 0, 0);
`endif
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
